vc_input_fifo: RTL
==================

# vc_input_fifo

Parametrised multi-virtual-channel input buffer for a router input port. Holds `NUM_VC` independent circular FIFOs of `2**ADDR_WIDTH` flits each, written from the link side and read by the input controller. Read data is registered and returned with a one-cycle grant. Adds per-VC occupancy, almost-full and optional error flags to the single-queue port buffer.

## Interface
- `DATA_WIDTH`, 32, flit width in bits.
- `ADDR_WIDTH`, 4, log2 of per-VC depth (DEPTH = 16).
- `NUM_VC`, 2, number of virtual channels, range 1..8.
- `AF_THRESH`, 2, `almost_full[v]` asserts when free slots ≤ AF_THRESH.
- Localparam `VC_BITS` = max(1, clog2(NUM_VC)).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `inout_select` in 1: link currently drives flits into this port; acts as write enable.
- `wr_vc` in VC_BITS: target VC of the incoming flit.
- `PacketIn` in DATA_WIDTH: incoming flit.
- `reqInCtr` in 1: read request from the input controller.
- `rd_vc` in VC_BITS: VC to pop.
- `gntInCtr` out 1: registered read grant; `PacketOut` valid while high.
- `PacketOut` out DATA_WIDTH: registered head flit.
- `PacketOut_vc` out VC_BITS: VC of `PacketOut`.
- `full`, `empty`, `almost_full` out NUM_VC: per-VC status.
- `count` out NUM_VC*(ADDR_WIDTH+1): per-VC occupancy, VC v at bits [v*(ADDR_WIDTH+1) +: ADDR_WIDTH+1].
- `err_ovf`, `err_udf` out NUM_VC: sticky error flags (see Configuration).

## Operation
- Per VC: `wr_ptr`/`rd_ptr` are ADDR_WIDTH+1 bits (MSB is the wrap bit). `empty` = pointers equal. `full` = low bits equal and MSBs differ. `count` = wr_ptr − rd_ptr mod 2**(ADDR_WIDTH+1).
- Write is accepted when `inout_select && wr_vc < NUM_VC && !full[wr_vc]`. Storage at the wr_ptr address takes `PacketIn`, and wr_ptr increments.
  - A write to a full VC is dropped.
  - A write to an out-of-range VC is dropped, with no flag.
- Read is accepted when `reqInCtr && rd_vc < NUM_VC && !empty[rd_vc]`. Next edge: `gntInCtr`=1, `PacketOut`=head, `PacketOut_vc`=rd_vc, rd_ptr increments.
  - Otherwise `gntInCtr`=0 and `PacketOut`/`PacketOut_vc` hold their last values.
- Status flags are computed from registered pointers only:
  - No write-to-read bypass. A read of an empty VC is refused even if a write to it arrives in the same cycle.
  - A write to a full VC is refused even if a read of it happens in the same cycle.
- Same-VC simultaneous accepted read and write: both occur, count unchanged. Different VCs operate fully independently.
- Pointers wrap naturally modulo 2**(ADDR_WIDTH+1). Data order within a VC is strict FIFO.
- Reset: all pointers 0 and `gntInCtr`=0. `PacketOut` is 0 and `PacketOut_vc` is 0, never Z. Error flags are 0. Storage is not cleared and not readable afterwards.
- Reset mid-operation discards all contents and dominates any same-cycle read or write.

## Timing
- Reset values after the first edge with rst=1:
  - `empty` all 1.
  - `full`, `almost_full`, `count`, `gntInCtr`, `PacketOut`, `PacketOut_vc`, `err_*` all 0.
- Write on edge N: `empty` falls and `count` updates after edge N.
- Read request in cycle N+1 is granted at edge N+1, so minimum write-to-`PacketOut` latency is 2 cycles.
- Back-to-back reads: one flit per cycle. `gntInCtr` stays high each cycle following an accepted request.
- `full` rises after the edge of the DEPTH-th outstanding write. `almost_full` rises when count ≥ DEPTH − AF_THRESH (14 at defaults).

## Configuration
- `VC_FIFO_ERR_EN` defined:
  - `err_ovf[v]` sets when `inout_select` targets VC v while `full[v]`.
  - `err_udf[v]` sets when `reqInCtr` targets VC v while `empty[v]`.
  - Both are sticky and cleared only by rst.
- Not defined: `err_ovf`/`err_udf` are tied 0 and no error flops are built. Data path behaviour is identical.

## Test plan
- rst high 2 cycles while count[0]=7 → `empty`=2'b11, count 0, `gntInCtr`=0, `PacketOut`=0. A following read of VC0 gets no grant.
- 16 writes 0x00..0x0F to VC0:
  - `almost_full[0]` rises after the 14th write and `full[0]` after the 16th.
  - A 17th write (0xFF) is dropped, count[0]=16, VC1 stays empty.
- Drain VC0 with reqInCtr held 16 cycles → `PacketOut` 0x00..0x0F on consecutive cycles, `gntInCtr`=1 each, `PacketOut_vc`=0, then `empty[0]`=1 and `gntInCtr`=0.
- VC0 holding 5 flits, simultaneous write+read for 20 cycles (forcing pointer wrap) → count[0] stays 5, output order equals input order.
- Write 0xA to VC0, then 0xB to VC1; read VC1, then VC0 → `PacketOut` 0xB (vc 1), then 0xA (vc 0).
- With `VC_FIFO_ERR_EN`:
  - Write to full VC0 → `err_ovf`=2'b01, held until rst.
  - Read of empty VC1 → `err_udf`=2'b10.
  - Without the macro, both stay 0.

Source files
------------

// File: rtl/vc_input_fifo.sv
// Multi-virtual-channel input buffer: NUM_VC independent circular FIFOs with a registered read port.
// Optional sticky overflow/underflow flags are built only when VC_FIFO_ERR_EN is defined.
module vc_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_VC     = 2,
    parameter int AF_THRESH  = 2,
    localparam int VC_BITS   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               inout_select,
    input  logic [VC_BITS-1:0]                 wr_vc,
    input  logic [DATA_WIDTH-1:0]              PacketIn,
    input  logic                               reqInCtr,
    input  logic [VC_BITS-1:0]                 rd_vc,
    output logic                               gntInCtr,
    output logic [DATA_WIDTH-1:0]              PacketOut,
    output logic [VC_BITS-1:0]                 PacketOut_vc,
    output logic [NUM_VC-1:0]                  full,
    output logic [NUM_VC-1:0]                  empty,
    output logic [NUM_VC-1:0]                  almost_full,
    output logic [NUM_VC*(ADDR_WIDTH+1)-1:0]   count,
    output logic [NUM_VC-1:0]                  err_ovf,
    output logic [NUM_VC-1:0]                  err_udf
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]      AF_LEVEL = PW'(DEPTH - AF_THRESH);
    localparam logic [VC_BITS:0]   VC_LIMIT = (VC_BITS + 1)'(NUM_VC);

    logic [DATA_WIDTH-1:0] mem    [NUM_VC][DEPTH];
    logic [PW-1:0]         wr_ptr [NUM_VC];
    logic [PW-1:0]         rd_ptr [NUM_VC];

    logic                  wr_vc_ok;
    logic                  rd_vc_ok;
    logic                  wr_en;
    logic                  vld_p0;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [VC_BITS-1:0]    vc_p1;

    // Status comes from registered pointers only, so same-cycle traffic never bypasses it.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [PW-1:0] occ;
        assign occ            = wr_ptr[v] - rd_ptr[v];
        assign empty[v]       = (wr_ptr[v] == rd_ptr[v]);
        assign full[v]        = (wr_ptr[v][ADDR_WIDTH-1:0] == rd_ptr[v][ADDR_WIDTH-1:0]) &&
                                (wr_ptr[v][ADDR_WIDTH] != rd_ptr[v][ADDR_WIDTH]);
        assign almost_full[v] = (occ >= AF_LEVEL);
        assign count[v*PW +: PW] = occ;
    end

    assign wr_vc_ok = ({1'b0, wr_vc} < VC_LIMIT);
    assign rd_vc_ok = ({1'b0, rd_vc} < VC_LIMIT);
    assign wr_en    = inout_select && wr_vc_ok && !full[wr_vc];
    assign vld_p0   = reqInCtr && rd_vc_ok && !empty[rd_vc];

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_vc][wr_ptr[wr_vc][ADDR_WIDTH-1:0]] <= PacketIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
        end else begin
            if (wr_en) begin
                wr_ptr[wr_vc] <= wr_ptr[wr_vc] + PW'(1);
            end
            if (vld_p0) begin
                rd_ptr[rd_vc] <= rd_ptr[rd_vc] + PW'(1);
            end
        end
    end

    // p0 -> p1: head flit registered; data and VC hold when no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            vc_p1   <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                data_p1 <= mem[rd_vc][rd_ptr[rd_vc][ADDR_WIDTH-1:0]];
                vc_p1   <= rd_vc;
            end
        end
    end

    assign gntInCtr     = vld_p1;
    assign PacketOut    = data_p1;
    assign PacketOut_vc = vc_p1;

`ifdef VC_FIFO_ERR_EN
    logic [NUM_VC-1:0] ovf_q;
    logic [NUM_VC-1:0] udf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (inout_select && (wr_vc == VC_BITS'(v)) && full[v]) begin
                    ovf_q[v] <= 1'b1;
                end
                if (reqInCtr && (rd_vc == VC_BITS'(v)) && empty[v]) begin
                    udf_q[v] <= 1'b1;
                end
            end
        end
    end

    assign err_ovf = ovf_q;
    assign err_udf = udf_q;
`else
    assign err_ovf = '0;
    assign err_udf = '0;
`endif

endmodule
